// File: rtl/shift_add_multiplier_if.sv
// Port bundle for the shift-and-add multiplier: request/result handshake plus
// the operand/result wires of the external combinational adder.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 START;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   PRODUCT;
    logic [WIDTH-1:0]     ADD_A;
    logic [WIDTH-1:0]     ADD_B;
    logic [WIDTH-1:0]     ADD_SUM;
    logic                 ADD_CARRY;

    // master: the surrounding level (requester and adder)
    modport master (
        output START, A, B, ADD_SUM, ADD_CARRY,
        input  BUSY, DONE, PRODUCT, ADD_A, ADD_B
    );

    modport slave (
        input  START, A, B, ADD_SUM, ADD_CARRY,
        output BUSY, DONE, PRODUCT, ADD_A, ADD_B
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTHxWIDTH multiplier: one pass of the external adder per
// multiplier bit, fixed latency of WIDTH passes, one-cycle DONE pulse.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    shift_add_multiplier_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  m;
    logic [PW-1:0]     p;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     product;
    logic [PW-1:0]     p_shift;
    logic              load, step, finish, busy, done;

    // Adder result joined with the untouched multiplier bits, shifted right by one;
    // the carry lands in the top bit so nothing is lost.
    assign p_shift = {bus.ADD_CARRY, bus.ADD_SUM, p[WIDTH-1:1]};

    assign bus.ADD_A   = p[PW-1:WIDTH];
    assign bus.ADD_B   = p[0] ? m : '0;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.PRODUCT = product;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    load      = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                m   <= bus.A;
                p   <= {{WIDTH{1'b0}}, bus.B};
                cnt <= '0;
            end
            if (step) begin
                p   <= p_shift;
                cnt <= cnt + 1'b1;
            end
            if (finish) product <= p_shift;
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed + random checks of shift_add_multiplier against plain a*b arithmetic,
// with a behavioural 8-bit adder closing the loop.
module tb_shift_add_multiplier;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_add_multiplier_if #(.WIDTH(8)) bus ();

    shift_add_multiplier #(.WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [8:0] add_res;
    assign add_res       = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B};
    assign bus.ADD_SUM   = add_res[7:0];
    assign bus.ADD_CARRY = add_res[8];

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start a*b, optionally re-pulse START (with junk operands) in the cycles set in
    // poke, and watch a 20-cycle window after the accepting edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] poke, input string tag);
        logic [15:0] exp;
        logic [15:0] prod;
        int busy_n, done_n, done_at;
        exp     = 16'(a) * 16'(b);
        prod    = '0;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        bus.A = a; bus.B = b; bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
        for (int c = 1; c <= 20; c++) begin
            if (poke[c]) begin
                bus.START = 1'b1; bus.A = 8'd200; bus.B = 8'd200;
            end else begin
                bus.START = 1'b0;
            end
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c;
                    prod    = bus.PRODUCT;
                end
            end
            tick();
        end
        bus.START = 1'b0;
        check({tag, " done_latency"}, done_at, 9);
        check({tag, " busy_cycles"}, busy_n, 8);
        check({tag, " done_count"}, done_n, 1);
        check({tag, " product"}, prod, exp);
        check({tag, " product_hold"}, bus.PRODUCT, exp);
    endtask

    initial begin
        int done_n;
        int d1_at, d2_at;
        logic [15:0] p1, p2, p_before2;

        bus.START = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("rst add_a", bus.ADD_A, 0);
        check("rst add_b", bus.ADD_B, 0);
        check("rst product", bus.PRODUCT, 0);
        check("rst busy", bus.BUSY, 0);
        check("rst done", bus.DONE, 0);

        run_op(8'd13,  8'd11,  32'h0, "13x11");
        run_op(8'hFF,  8'hFF,  32'h0, "ffxff");
        run_op(8'h00,  8'hA5,  32'h0, "0xa5");
        run_op(8'h5A,  8'h00,  32'h0, "5ax0");
        // Re-START during CALC (cycles 3, 8) and during the DONE cycle (9)
        run_op(8'd7,   8'd6,   32'h0000_0308, "ignore_start");

        // Reset mid-operation, asserted between edges
        bus.A = 8'd100; bus.B = 8'd3; bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (3) tick();
        #2;
        RST = 1'b1;
        #1;
        check("midrst busy", bus.BUSY, 0);
        check("midrst product", bus.PRODUCT, 0);
        check("midrst add_a", bus.ADD_A, 0);
        check("midrst done", bus.DONE, 0);
        #1;
        RST = 1'b0;
        done_n = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.DONE) done_n++;
        end
        check("midrst no_done", done_n, 0);
        run_op(8'd100, 8'd3, 32'h0, "100x3");

        // START held high; operands changed during the first CALC
        bus.A = 8'd16; bus.B = 8'd16; bus.START = 1'b1;
        tick();
        bus.A = 8'd3; bus.B = 8'd5;
        d1_at = 0; d2_at = 0; p1 = '0; p2 = '0; p_before2 = '0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 18) p_before2 = bus.PRODUCT;
            if (bus.DONE) begin
                if (d1_at == 0) begin
                    d1_at = c; p1 = bus.PRODUCT;
                end else if (d2_at == 0) begin
                    d2_at = c; p2 = bus.PRODUCT;
                end
            end
            tick();
        end
        bus.START = 1'b0;
        check("hold first_latency", d1_at, 9);
        check("hold first_product", p1, 16'(16 * 16));
        // DONE at 9, IDLE at 10 accepts, so the next DONE lands 9 cycles later
        check("hold second_latency", d2_at, 19);
        check("hold second_product", p2, 16'(3 * 5));
        check("hold product_held", p_before2, 16'(16 * 16));
        repeat (15) tick();

        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
            run_op(ra, rb, 32'h0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
